// File: rtl/snax_mx_output_serializer.sv
// snax_mx_output_serializer
// Buffers wide MX result words (64 data bytes + shared exponent) in a small
// FIFO and serializes each word into OutDataWidth beats for a narrow writer
// streamer. out_last_o marks the final beat of every word.
// Optional build macro: SNAX_MX_OUT_SER_EXP_BEAT_EN
//   defined   -> each word ends with an extra beat carrying the exponent byte
//   undefined -> exponent is dropped, last beat is data beat DataBeats-1
module snax_mx_output_serializer #(
    parameter int InDataWidth  = 576,
    parameter int OutDataWidth = 64,
    parameter int DataBeats    = 8,
    parameter int FifoDepth    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [InDataWidth-1:0]  in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [OutDataWidth-1:0] out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_last_o,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic [31:0]             word_cnt_o
);

    localparam int ExpW   = 8;
    localparam int ExpLsb = DataBeats * OutDataWidth;
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
    localparam int StoreW = ExpLsb + ExpW;
`else
    localparam int StoreW = ExpLsb;
`endif
    localparam int BeatW = (DataBeats > 1) ? $clog2(DataBeats) : 1;
    localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW  = $clog2(FifoDepth + 1);

`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
    typedef enum logic {
        ST_DATA = 1'b0,
        ST_EXP  = 1'b1
    } state_e;
    state_e state_q, state_d;
`endif

    // Only the bits that can ever be emitted are stored.
    logic [StoreW-1:0] mem_q [FifoDepth];
    logic [StoreW-1:0] head_word;

    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [31:0]      word_cnt_q, word_cnt_d;

    logic push;
    logic fire;
    logic last_beat;
    logic pop;

    logic unused_in_bits;
    assign unused_in_bits = ^in_data_i[InDataWidth-1:StoreW];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(FifoDepth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Handshakes depend on registered state only: no full-bypass, no in->out path.
    assign in_ready_o  = (count_q != CntW'(FifoDepth));
    assign out_valid_o = (count_q != '0);
    assign busy_o      = (count_q != '0);
    assign word_cnt_o  = word_cnt_q;
    assign push        = in_valid_i && in_ready_o;
    assign fire        = out_valid_o && out_ready_i;
    assign head_word   = mem_q[rd_ptr_q];

`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
    assign last_beat = (state_q == ST_EXP);
`else
    assign last_beat = (beat_q == BeatW'(DataBeats - 1));
`endif
    assign out_last_o = out_valid_o && last_beat;
    assign pop        = fire && last_beat;

    // Word storage: written on every accepted push unless flushed this cycle.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            mem_q[wr_ptr_q] <= in_data_i[StoreW-1:0];
        end
    end

    // Beat mux: head word slice selected by the beat counter, zero when idle.
    always_comb begin
        out_data_o = '0;
        if (out_valid_o) begin
            out_data_o = head_word[int'(beat_q)*OutDataWidth +: OutDataWidth];
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
            if (state_q == ST_EXP) begin
                out_data_o = {{(OutDataWidth-ExpW){1'b0}}, head_word[ExpLsb +: ExpW]};
            end
`endif
        end
    end

    // Next-state logic: pointers, occupancy, beat sequencing, word counter.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        word_cnt_d = word_cnt_q;
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
        state_d    = state_q;
`endif
        if (clear_i) begin
            // Flush wins over any same-cycle push or pop.
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            beat_d     = '0;
            word_cnt_d = '0;
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
            state_d    = ST_DATA;
`endif
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (fire) begin
                if (last_beat) begin
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    beat_d     = '0;
                    word_cnt_d = word_cnt_q + 32'd1;
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
                    state_d    = ST_DATA;
`endif
                end else begin
`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
                    if (beat_q == BeatW'(DataBeats - 1)) begin
                        state_d = ST_EXP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
`else
                    beat_d = beat_q + BeatW'(1);
`endif
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset discards any partially sent word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_q     <= beat_d;
            word_cnt_q <= word_cnt_d;
        end
    end

`ifdef SNAX_MX_OUT_SER_EXP_BEAT_EN
    // FSM state register (DATA / EXP).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_DATA;
        end else begin
            state_q <= state_d;
        end
    end
`endif

endmodule
